clock_set_controller: RTL and testbench

Sequencing controller for the digital clock's timekeeping datapath. Owns the hour, minute and second registers and advances them on an external one-second tick. Runs the set-mode state machine that lets the user edit one field at a time with the `mode`, `set`, `op1` and `op2` buttons. Drives `display_mode`, the per-field `flash` mask and the packed `out_time` bus consumed by the display controller.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/clock_set_controller_if.sv | 24 ++
 rtl/clock_set_controller_button_edge.sv | 27 ++
 rtl/clock_set_controller.sv | 92 +++++++++
 tb/tb_clock_set_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types, limits and helpers for the clock set-mode controller.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN,
      SET_HOUR,
      SET_MIN,
      SET_SEC
   } set_state_t;

   localparam int FIELD_W = 7;
   localparam int TIME_W  = 3 * FIELD_W;

   typedef logic [FIELD_W-1:0] field_t;

   localparam field_t MAX_HOUR = 7'd23;
   localparam field_t MAX_MIN  = 7'd59;
   localparam field_t MAX_SEC  = 7'd59;

   // One step up or down with wrap between 0 and max_val; used for both tick carry and edits.
   function automatic field_t wrap_step(input field_t val, input field_t max_val, input logic up);
      if (up)
         return (val >= max_val) ? '0 : val + field_t'(1);
      else
         return (val == '0) ? max_val : val - field_t'(1);
   endfunction

   // out_time packing: {hour, min, sec}, hour in the top field.
   function automatic logic [TIME_W-1:0] pack_time(input field_t hour_f, input field_t min_f,
                                                   input field_t sec_f);
      return {hour_f, min_f, sec_f};
   endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button, tick and display-facing signals of the clock set-mode controller.
interface clock_set_controller_if;

   logic                         mode;
   logic                         set;
   logic                         op1;
   logic                         op2;
   logic                         tick;
   logic                         display_mode;
   logic [2:0]                   flash;
   logic [clock_pkg::TIME_W-1:0] out_time;
   logic                         set_active;

   modport master (
      output mode, set, op1, op2, tick,
      input  display_mode, flash, out_time, set_active
   );

   modport slave (
      input  mode, set, op1, op2, tick,
      output display_mode, flash, out_time, set_active
   );

endinterface

// File: rtl/clock_set_controller_button_edge.sv
// Button synchronizer followed by a registered rising-edge detector.
module button_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // Registered pulse: a level rising at edge N yields the event at edge N+SYNC_STAGES.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync  <= '0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], din};
         prev  <= sync[SYNC_STAGES-1];
         pulse <= sync[SYNC_STAGES-1] & ~prev;
      end
   end

endmodule

// File: rtl/clock_set_controller.sv
// Timekeeping registers plus the set-mode FSM that edits hour/min/sec one field at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   RUN      | time advances on tick, mode toggles 12/24h
//   SET_HOUR | time frozen, op1/op2 edit hour
//   SET_MIN  | time frozen, op1/op2 edit minute
//   SET_SEC  | time frozen, op1/op2 edit second
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input logic                   clk,
   input logic                   reset,
   clock_set_controller_if.slave bus
);

   logic mode_ev, set_ev, op1_ev, op2_ev;

   button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode (.clk(clk), .reset(reset), .din(bus.mode), .pulse(mode_ev));
   button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_set  (.clk(clk), .reset(reset), .din(bus.set),  .pulse(set_ev));
   button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_op1  (.clk(clk), .reset(reset), .din(bus.op1),  .pulse(op1_ev));
   button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_op2  (.clk(clk), .reset(reset), .din(bus.op2),  .pulse(op2_ev));

   set_state_t state;
   field_t     hour_q, min_q, sec_q;
   logic       display_mode_q;
   logic [2:0] flash_q;
   logic       set_active_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= RUN;
         hour_q         <= '0;
         min_q          <= '0;
         sec_q          <= '0;
         display_mode_q <= 1'b0;
         flash_q        <= 3'b000;
         set_active_q   <= 1'b0;
      end else if (state == RUN) begin
         // Tick is applied even when a set event moves us out of RUN this cycle.
         if (bus.tick) begin
            sec_q <= wrap_step(sec_q, MAX_SEC, 1'b1);
            if (sec_q == MAX_SEC) begin
               min_q <= wrap_step(min_q, MAX_MIN, 1'b1);
               if (min_q == MAX_MIN)
                  hour_q <= wrap_step(hour_q, MAX_HOUR, 1'b1);
            end
         end
         if (mode_ev) begin
            display_mode_q <= ~display_mode_q;
         end else if (set_ev) begin
            state        <= SET_HOUR;
            flash_q      <= 3'b100;
            set_active_q <= 1'b1;
         end
      end else if (mode_ev) begin
         state        <= RUN;
         flash_q      <= 3'b000;
         set_active_q <= 1'b0;
      end else if (set_ev) begin
         case (state)
            SET_HOUR: begin
               state   <= SET_MIN;
               flash_q <= 3'b010;
            end
            SET_MIN: begin
               state   <= SET_SEC;
               flash_q <= 3'b001;
            end
            default: begin
               state        <= RUN;
               flash_q      <= 3'b000;
               set_active_q <= 1'b0;
            end
         endcase
      end else if (op1_ev ^ op2_ev) begin
         case (state)
            SET_HOUR: hour_q <= wrap_step(hour_q, MAX_HOUR, op1_ev);
            SET_MIN:  min_q  <= wrap_step(min_q, MAX_MIN, op1_ev);
            default:  sec_q  <= wrap_step(sec_q, MAX_SEC, op1_ev);
         endcase
      end
   end

   assign bus.out_time     = pack_time(hour_q, min_q, sec_q);
   assign bus.display_mode = display_mode_q;
   assign bus.flash        = flash_q;
   assign bus.set_active   = set_active_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller against a seconds-of-day reference model.
module tb_clock_set_controller;

   localparam int SYNC_STAGES = 2;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   int   model_t;
   int   model_field;
   logic model_dm;

   clock_set_controller_if bus();

   clock_set_controller #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [25:0] exp_outputs();
      int h, m, s;
      logic [2:0] f;
      h = model_t / 3600;
      m = (model_t / 60) % 60;
      s = model_t % 60;
      case (model_field)
         1:       f = 3'b100;
         2:       f = 3'b010;
         3:       f = 3'b001;
         default: f = 3'b000;
      endcase
      return {model_dm, f, (model_field != 0), 7'(h), 7'(m), 7'(s)};
   endfunction

   function automatic logic [25:0] observed();
      return {bus.display_mode, bus.flash, bus.set_active, bus.out_time};
   endfunction

   // b = {mode, set, op1, op2}
   function automatic void model_event(input logic [3:0] b);
      int h, m, s, v, mx;
      if (model_field == 0) begin
         if (b[3]) model_dm = ~model_dm;
         else if (b[2]) model_field = 1;
      end else if (b[3]) begin
         model_field = 0;
      end else if (b[2]) begin
         model_field = (model_field + 1) % 4;
      end else if (b[1] != b[0]) begin
         h  = model_t / 3600;
         m  = (model_t / 60) % 60;
         s  = model_t % 60;
         mx = (model_field == 1) ? 24 : 60;
         v  = (model_field == 1) ? h : (model_field == 2) ? m : s;
         v  = b[1] ? (v + 1) % mx : (v + mx - 1) % mx;
         if (model_field == 1) h = v;
         else if (model_field == 2) m = v;
         else s = v;
         model_t = h * 3600 + m * 60 + s;
      end
   endfunction

   function automatic void model_tick();
      if (model_field == 0) model_t = (model_t + 1) % 86400;
   endfunction

   task automatic press(input logic [3:0] b, input int hold);
      bus.mode = b[3];
      bus.set  = b[2];
      bus.op1  = b[1];
      bus.op2  = b[0];
      repeat (hold) @(negedge clk);
      bus.mode = 1'b0;
      bus.set  = 1'b0;
      bus.op1  = 1'b0;
      bus.op2  = 1'b0;
      repeat (SYNC_STAGES + 3) @(negedge clk);
      model_event(b);
   endtask

   task automatic run_ticks(input int n);
      bus.tick = 1'b1;
      repeat (n) begin
         @(negedge clk);
         model_tick();
      end
      bus.tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      model_t = 0; model_field = 0; model_dm = 1'b0;
      checks++;
      if (observed() !== 26'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", observed(), 26'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL reset_release: got %h expected %h", observed(), exp_outputs());
      end
   endtask

   task automatic test_full_day();
      logic [20:0] t_0059, t_0100, t_2359, t_0000;
      t_0059 = {7'd0, 7'd59, 7'd59};
      t_0100 = {7'd1, 7'd0, 7'd0};
      t_2359 = {7'd23, 7'd59, 7'd59};
      t_0000 = '0;
      bus.tick = 1'b1;
      for (int i = 1; i <= 86400; i++) begin
         @(negedge clk);
         model_tick();
         if (i % 5000 == 0 || i == 3599 || i == 3600 || i == 86399 || i == 86400) begin
            checks++;
            if (observed() !== exp_outputs()) begin
               failures++;
               $display("FAIL full_day tick %0d: got %h expected %h", i, observed(), exp_outputs());
            end
         end
         if (i == 3599 || i == 3600 || i == 86399 || i == 86400) begin
            checks++;
            if (bus.out_time !== ((i == 3599) ? t_0059 : (i == 3600) ? t_0100 :
                                  (i == 86399) ? t_2359 : t_0000)) begin
               failures++;
               $display("FAIL full_day_boundary tick %0d: got %h", i, bus.out_time);
            end
         end
      end
      bus.tick = 1'b0;
   endtask

   task automatic test_set_sequence();
      logic [3:0] seq [8];
      logic [20:0] final_t;
      seq = '{4'b0100, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
      final_t = {7'd23, 7'd3, 7'd0};
      for (int i = 0; i < 8; i++) begin
         press(seq[i], 2);
         checks++;
         if (observed() !== exp_outputs()) begin
            failures++;
            $display("FAIL set_sequence step %0d: got %h expected %h", i, observed(), exp_outputs());
         end
      end
      checks++;
      if (bus.out_time !== final_t || bus.set_active !== 1'b0) begin
         failures++;
         $display("FAIL set_sequence_final: got time %h active %b expected %h 0",
                  bus.out_time, bus.set_active, final_t);
      end
   endtask

   task automatic test_min_wrap_freeze();
      logic [25:0] snap;
      press(4'b0100, 1);
      press(4'b0100, 1);
      for (int i = 0; i < 60 && ((model_t / 60) % 60) != 59; i++) press(4'b0001, 1);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL min_at_59: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b0010, 1);
      checks++;
      if (bus.out_time[13:7] !== 7'd0 || bus.out_time[20:14] !== 7'(model_t / 3600) ||
          observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL min_wrap_no_carry: got %h expected %h", observed(), exp_outputs());
      end
      snap = exp_outputs();
      run_ticks(20);
      checks++;
      if (observed() !== snap) begin
         failures++;
         $display("FAIL set_freeze: got %h expected %h", observed(), snap);
      end
      press(4'b1000, 1);
   endtask

   task automatic test_mode();
      press(4'b1000, 2);
      checks++;
      if (bus.display_mode !== 1'b1 || observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL mode_toggle_on: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b1000, 2);
      checks++;
      if (bus.display_mode !== 1'b0 || observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL mode_toggle_off: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b0100, 1);
      press(4'b0010, 1);
      press(4'b1000, 1);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL mode_abort: got %h expected %h", observed(), exp_outputs());
      end
   endtask

   task automatic test_simultaneous();
      press(4'b0100, 1);
      press(4'b0011, 2);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL op1_op2_same: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b0110, 2);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL set_op1_same: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b1000, 1);
      press(4'b1100, 2);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL set_mode_run: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b1000, 1);
      // Align the tick with the cycle the set event reaches the FSM.
      bus.set = 1'b1;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      bus.set  = 1'b0;
      model_tick();
      model_event(4'b0100);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL tick_with_set: got %h expected %h", observed(), exp_outputs());
      end
      repeat (SYNC_STAGES + 3) @(negedge clk);
      press(4'b1000, 1);
   endtask

   task automatic test_hold();
      press(4'b0100, 1);
      bus.op1 = 1'b1;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL hold_too_early: got %h expected %h", observed(), exp_outputs());
      end
      @(negedge clk);
      model_event(4'b0010);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL hold_latency: got %h expected %h", observed(), exp_outputs());
      end
      repeat (1000 - (SYNC_STAGES + 2)) @(negedge clk);
      bus.op1 = 1'b0;
      repeat (SYNC_STAGES + 3) @(negedge clk);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL hold_single_event: got %h expected %h", observed(), exp_outputs());
      end
      press(4'b1000, 1);
   endtask

   task automatic test_random();
      logic [3:0] b;
      int r;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            run_ticks($urandom_range(1, 8));
         end else begin
            if (r == 1) b = 4'($urandom_range(1, 15));
            else b = 4'b0001 << $urandom_range(0, 3);
            press(b, $urandom_range(1, 3));
         end
         checks++;
         if (observed() !== exp_outputs()) begin
            failures++;
            $display("FAIL random step %0d: got %h expected %h", i, observed(), exp_outputs());
         end
      end
   endtask

   task automatic test_async_reset();
      logic [20:0] target;
      target = {7'd12, 7'd34, 7'd56};
      if (model_field != 0) press(4'b1000, 1);
      press(4'b0100, 1);
      press(4'b0100, 1);
      press(4'b0100, 1);
      for (int i = 0; i < 60 && (model_t % 60) != 56; i++) press(4'b0010, 1);
      press(4'b0100, 1);
      press(4'b0100, 1);
      for (int i = 0; i < 24 && (model_t / 3600) != 12; i++) press(4'b0010, 1);
      press(4'b0100, 1);
      for (int i = 0; i < 60 && ((model_t / 60) % 60) != 34; i++) press(4'b0010, 1);
      checks++;
      if (bus.out_time !== target || bus.flash !== 3'b010 || observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL pre_reset_state: got %h expected %h", observed(), exp_outputs());
      end
      #2 reset = 1'b0;
      #1;
      model_t = 0; model_field = 0; model_dm = 1'b0;
      checks++;
      if (observed() !== 26'd0) begin
         failures++;
         $display("FAIL async_reset: got %h expected %h", observed(), 26'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_ticks(1);
      checks++;
      if (observed() !== exp_outputs()) begin
         failures++;
         $display("FAIL after_reset_run: got %h expected %h", observed(), exp_outputs());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bus.mode = 1'b0;
      bus.set  = 1'b0;
      bus.op1  = 1'b0;
      bus.op2  = 1'b0;
      bus.tick = 1'b0;
      test_reset();
      test_full_day();
      test_set_sequence();
      test_min_wrap_freeze();
      test_mode();
      test_simultaneous();
      test_hold();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
